// File: rtl/attendant_call_pkg.sv
// attendant_call_pkg: shared state type, lamp codes and button bit positions.
package attendant_call_pkg;
   typedef enum logic [1:0] {IDLE, CALL, ESCALATE} state_t;
   localparam logic [1:0] LAMP_OFF  = 2'b00;
   localparam logic [1:0] LAMP_CALL = 2'b10;
   localparam logic [1:0] LAMP_ESC  = 2'b11;
   localparam int CALL_BTN   = 1;
   localparam int CANCEL_BTN = 0;
endpackage

// File: rtl/attendant_call_sync_bit.sv
// sync_bit: STAGES-deep single-bit synchronizer with async active-low reset.
module sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] chain;
   always_ff @(posedge clk or negedge reset)
      if (!reset) chain <= '0;
      else chain <= {chain[STAGES-2:0], d};
   assign q = chain[STAGES-1];
endmodule

// File: rtl/attendant_call.sv
// attendant_call: synchronized call/cancel buttons driving a Moore call-lamp FSM with escalation timeout.
module attendant_call
   import attendant_call_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int ESCALATE_CYCLES = 16,
   parameter int CNT_W           = $clog2(ESCALATE_CYCLES)
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] inputs,
   output logic [1:0] y_out
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(ESCALATE_CYCLES - 1);
   logic call_s, cancel_s;
   state_t state, next;
   logic [CNT_W-1:0] cnt, cnt_next;
   sync_bit #(.STAGES(SYNC_STAGES)) u_call (.clk(clk), .reset(reset), .d(inputs[CALL_BTN]), .q(call_s));
   sync_bit #(.STAGES(SYNC_STAGES)) u_cancel (.clk(clk), .reset(reset), .d(inputs[CANCEL_BTN]), .q(cancel_s));
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= next;
         cnt   <= cnt_next;
      end
   // cancel wins everywhere; the counter only advances while staying in CALL
   always_comb begin
      next = cancel_s ? IDLE
           : state == IDLE ? (call_s ? CALL : IDLE)
           : state == CALL ? (cnt == LAST ? ESCALATE : CALL)
           : state == ESCALATE ? ESCALATE : IDLE;
      cnt_next = (state == CALL && next == CALL) ? cnt + 1'b1 : '0;
      y_out = state == CALL ? LAMP_CALL : state == ESCALATE ? LAMP_ESC : LAMP_OFF;
   end
endmodule

// File: tb/tb_attendant_call.sv
// tb_attendant_call: directed vector table plus hand sequences for attendant_call.
module tb_attendant_call;
   typedef struct {
      logic       rst;
      logic [1:0] in;
      logic [1:0] exp;
      string      name;
   } vec_t;
   logic clk = 0;
   logic reset = 0;
   logic [1:0] inputs = 2'b11;
   logic [1:0] y_out;
   int vectors = 0;
   int errors = 0;
   vec_t tbl[$];
   attendant_call dut (.clk(clk), .reset(reset), .inputs(inputs), .y_out(y_out));
   always #5 clk = ~clk;
   function automatic void add(logic r, logic [1:0] i, logic [1:0] e, string n);
      tbl.push_back('{r, i, e, n});
   endfunction
   task automatic check(string n, logic [1:0] e);
      vectors++;
      if (y_out !== e) begin
         errors++;
         $display("FAIL %s: y_out=%b expected %b at %0t", n, y_out, e, $time);
      end
   endtask
   task automatic step(logic r, logic [1:0] i, logic [1:0] e, string n);
      @(negedge clk);
      reset = r;
      inputs = i;
      @(posedge clk);
      #1;
      check(n, e);
   endtask
   initial begin
      repeat (3) add(0, 2'b11, 2'b00, "reset_hold");
      repeat (3) add(1, 2'b00, 2'b00, "reset_release");
      add(1, 2'b10, 2'b00, "call_sync1");
      add(1, 2'b10, 2'b00, "call_sync2");
      add(1, 2'b00, 2'b10, "call_lamp");
      repeat (3) add(1, 2'b00, 2'b10, "call_latched");
      add(1, 2'b01, 2'b10, "cancel_sync1");
      add(1, 2'b00, 2'b10, "cancel_sync2");
      add(1, 2'b00, 2'b00, "cancel_done");
      add(1, 2'b00, 2'b00, "idle");
      add(1, 2'b10, 2'b00, "esc_arm1");
      add(1, 2'b00, 2'b00, "esc_arm2");
      repeat (16) add(1, 2'b00, 2'b10, "esc_call");
      repeat (3) add(1, 2'b00, 2'b11, "esc_alert");
      add(1, 2'b01, 2'b11, "esc_cancel1");
      add(1, 2'b00, 2'b11, "esc_cancel2");
      add(1, 2'b00, 2'b00, "esc_cancel3");
      repeat (4) add(1, 2'b11, 2'b00, "both_idle");
      add(1, 2'b10, 2'b00, "drop_cancel1");
      add(1, 2'b10, 2'b00, "drop_cancel2");
      add(1, 2'b10, 2'b10, "drop_cancel3");
      add(1, 2'b01, 2'b10, "prio_clean1");
      add(1, 2'b00, 2'b10, "prio_clean2");
      add(1, 2'b00, 2'b00, "prio_clean3");
      add(1, 2'b00, 2'b00, "prio_clean4");
      for (int i = 0; i < tbl.size(); i++) step(tbl[i].rst, tbl[i].in, tbl[i].exp, tbl[i].name);
      // re-press around counter 10 must not restart the timeout
      step(1, 2'b10, 2'b00, "repress_arm1");
      step(1, 2'b00, 2'b00, "repress_arm2");
      step(1, 2'b00, 2'b10, "repress_enter");
      for (int i = 1; i < 16; i++) step(1, (i == 8 || i == 9) ? 2'b10 : 2'b00, 2'b10, "repress_call");
      step(1, 2'b00, 2'b11, "repress_alert");
      step(1, 2'b00, 2'b11, "repress_alert_hold");
      @(posedge clk);
      #3;
      reset = 0;
      #1;
      check("async_reset_now", 2'b00);
      step(0, 2'b00, 2'b00, "async_reset_hold");
      for (int i = 0; i < 4; i++) step(1, 2'b00, 2'b00, "post_reset_idle");
      step(1, 2'b10, 2'b00, "post_reset_arm1");
      step(1, 2'b00, 2'b00, "post_reset_arm2");
      for (int i = 0; i < 16; i++) step(1, 2'b00, 2'b10, "post_reset_call");
      step(1, 2'b00, 2'b11, "post_reset_alert");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
